// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   owner_e     : requester identity (IFU=0, LSU=1), used for round-robin
//   WmaskWidth  : width of the byte write mask
package mem_arb_pkg;

   localparam int unsigned WmaskWidth = 8;

   typedef enum logic [1:0] {
      StIdle,
      StBusyIfu,
      StBusyLsu
   } arb_state_e;

   typedef enum logic {
      OwnerIfu = 1'b0,
      OwnerLsu = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch (read only) and load/store unit
// share one memory port. One outstanding transaction at a time. Ties are broken
// round-robin, and a transaction that waits too long for mem_ready ends with bus_err.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ifu_req/addr                  : fetch request
//   ifu_gnt/rvalid/rdata          : accept pulse, response pulse, read data
//   lsu_req/wen/addr/wdata/wmask  : load/store request (wen=1 store)
//   lsu_gnt/rvalid/rdata          : accept pulse, completion pulse, load data
//   mem_valid/wen/addr/wdata/wmask: shared memory request
//   mem_ready/rdata               : memory completion and read data
//   bus_err                       : one-cycle pulse on timeout
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req,
   input  logic [DATA_WIDTH-1:0] ifu_addr,
   output logic                  ifu_gnt,
   output logic                  ifu_rvalid,
   output logic [DATA_WIDTH-1:0] ifu_rdata,
   input  logic                  lsu_req,
   input  logic                  lsu_wen,
   input  logic [DATA_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   input  logic [WmaskWidth-1:0] lsu_wmask,
   output logic                  lsu_gnt,
   output logic                  lsu_rvalid,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic                  mem_valid,
   output logic                  mem_wen,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [WmaskWidth-1:0] mem_wmask,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  bus_err
);

   // Counter value during the last cycle a transaction may wait.
   localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

   arb_state_e            state_q;
   owner_e                last_owner_q;
   logic [7:0]            wait_cnt_q;
   logic [DATA_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [WmaskWidth-1:0] wmask_q;
   logic                  wen_q;

   logic idle, busy, ifu_win, lsu_win, timeout_hit, done;

   always_comb begin
      idle = (state_q == StIdle);
      busy = !idle;

      // LSU wins a tie only when IFU was served last.
      ifu_win = ifu_req && (!lsu_req || (last_owner_q == OwnerLsu));
      lsu_win = lsu_req && !ifu_win;
      ifu_gnt = idle && !rst && ifu_win;
      lsu_gnt = idle && !rst && lsu_win;

      // mem_ready in the final wait cycle still counts as a normal completion.
      timeout_hit = busy && !mem_ready && (wait_cnt_q == WaitLast);
      done        = busy && !rst && (mem_ready || timeout_hit);
      bus_err     = done && !mem_ready;

      ifu_rvalid = done && (state_q == StBusyIfu);
      lsu_rvalid = done && (state_q == StBusyLsu);
      ifu_rdata  = (ifu_rvalid && mem_ready) ? mem_rdata : '0;
      lsu_rdata  = (lsu_rvalid && mem_ready) ? mem_rdata : '0;

      mem_valid = busy;
      mem_wen   = busy && wen_q;
      mem_wmask = busy ? wmask_q : '0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_owner_q <= OwnerIfu;
         wait_cnt_q   <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         wen_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ifu_gnt) begin
                  state_q    <= StBusyIfu;
                  wait_cnt_q <= '0;
                  addr_q     <= ifu_addr;
                  wdata_q    <= '0;
                  wmask_q    <= '0;
                  wen_q      <= 1'b0;
               end else if (lsu_gnt) begin
                  state_q    <= StBusyLsu;
                  wait_cnt_q <= '0;
                  addr_q     <= lsu_addr;
                  wdata_q    <= lsu_wdata;
                  wmask_q    <= lsu_wmask;
                  wen_q      <= lsu_wen;
               end
            end
            StBusyIfu, StBusyLsu: begin
               if (done) begin
                  state_q      <= StIdle;
                  last_owner_q <= (state_q == StBusyIfu) ? OwnerIfu : OwnerLsu;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants and responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req, ifu_gnt, ifu_rvalid;
   logic [DW-1:0] ifu_addr, ifu_rdata;
   logic          lsu_req, lsu_wen, lsu_gnt, lsu_rvalid;
   logic [DW-1:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]    lsu_wmask;
   logic          mem_valid, mem_wen, mem_ready, bus_err;
   logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]    mem_wmask;

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .ifu_req    (ifu_req),
      .ifu_addr   (ifu_addr),
      .ifu_gnt    (ifu_gnt),
      .ifu_rvalid (ifu_rvalid),
      .ifu_rdata  (ifu_rdata),
      .lsu_req    (lsu_req),
      .lsu_wen    (lsu_wen),
      .lsu_addr   (lsu_addr),
      .lsu_wdata  (lsu_wdata),
      .lsu_wmask  (lsu_wmask),
      .lsu_gnt    (lsu_gnt),
      .lsu_rvalid (lsu_rvalid),
      .lsu_rdata  (lsu_rdata),
      .mem_valid  (mem_valid),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .bus_err    (bus_err)
   );

   typedef struct packed {
      logic          lsu;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   bit   gnt_q[$];   // 1 = LSU expected to be granted
   rsp_t rsp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push_gnt(input bit lsu);
      gnt_q.push_back(lsu);
   endtask

   task automatic push_rsp(input logic lsu, input logic [DW-1:0] rdata, input logic err);
      rsp_t r;
      r.lsu   = lsu;
      r.rdata = rdata;
      r.err   = err;
      rsp_q.push_back(r);
   endtask

   // Monitor
   always @(negedge clk) begin
      bit   eg;
      rsp_t er, ar;
      check("gnt_exclusive", 64'(ifu_gnt & lsu_gnt), 64'd0);
      check("rvalid_exclusive", 64'(ifu_rvalid & lsu_rvalid), 64'd0);
      check("ifu_rdata_zero_when_idle", ifu_rvalid ? 64'd0 : 64'(ifu_rdata), 64'd0);
      check("lsu_rdata_zero_when_idle", lsu_rvalid ? 64'd0 : 64'(lsu_rdata), 64'd0);
      check("bus_err_only_with_rvalid", 64'(bus_err & ~(ifu_rvalid | lsu_rvalid)), 64'd0);
      if (ifu_gnt || lsu_gnt) begin
         if (gnt_q.size() == 0) begin
            check("unexpected_gnt", {62'd0, ifu_gnt, lsu_gnt}, 64'd0);
         end else begin
            eg = gnt_q.pop_front();
            check("gnt_owner", {62'd0, ifu_gnt, lsu_gnt}, eg ? 64'd1 : 64'd2);
         end
      end
      if (ifu_rvalid || lsu_rvalid) begin
         ar.lsu   = lsu_rvalid;
         ar.rdata = lsu_rvalid ? lsu_rdata : ifu_rdata;
         ar.err   = bus_err;
         if (rsp_q.size() == 0) begin
            check("unexpected_rvalid", 64'(ar), 64'd0);
         end else begin
            er = rsp_q.pop_front();
            check("response", 64'(ar), 64'(er));
         end
      end
   end

   initial begin
      rst = 1'b1;
      ifu_req = 1'b1; ifu_addr = '0;
      lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
      mem_ready = 1'b0; mem_rdata = '0;

      // Reset with both requesters active: no grants allowed
      repeat (3) cyc();
      smp();
      check("rst_no_ifu_gnt", 64'(ifu_gnt), 64'd0);
      check("rst_no_lsu_gnt", 64'(lsu_gnt), 64'd0);
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      check("rst_bus_err", 64'(bus_err), 64'd0);
      cyc();
      rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0;
      smp();
      check("idle_mem_valid", 64'(mem_valid), 64'd0);

      // Minimal IFU fetch
      cyc();
      ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
      push_gnt(1'b0); push_rsp(1'b0, 32'h0000_0413, 1'b0);
      smp();
      check("t1_ifu_gnt", 64'(ifu_gnt), 64'd1);
      check("t1_mem_valid_n", 64'(mem_valid), 64'd0);
      cyc();
      ifu_req = 1'b0; ifu_addr = '0; mem_ready = 1'b1; mem_rdata = 32'h0000_0413;
      smp();
      check("t1_mem_valid", 64'(mem_valid), 64'd1);
      check("t1_mem_addr", 64'(mem_addr), 64'h8000_0000);
      check("t1_mem_wen", 64'(mem_wen), 64'd0);
      check("t1_mem_wmask", 64'(mem_wmask), 64'd0);
      check("t1_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
      cyc();
      mem_ready = 1'b0; mem_rdata = '0;
      smp();
      check("t1_back_idle", 64'(mem_valid), 64'd0);

      // Round-robin after reset: LSU first, then IFU
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      ifu_req = 1'b1; ifu_addr = 32'h200;
      lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h100;
      push_gnt(1'b1); push_rsp(1'b1, 32'h11, 1'b0);
      smp();
      check("t2_lsu_gnt", 64'(lsu_gnt), 64'd1);
      cyc();
      mem_ready = 1'b1; mem_rdata = 32'h11;
      smp();
      check("t2_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
      check("t2_lsu_addr", 64'(mem_addr), 64'h100);
      cyc();
      mem_ready = 1'b0; mem_rdata = '0;
      push_gnt(1'b0); push_rsp(1'b0, 32'h22, 1'b0);
      smp();
      check("t2_ifu_gnt", 64'(ifu_gnt), 64'd1);
      cyc();
      ifu_req = 1'b0; lsu_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h22;
      smp();
      check("t2_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
      check("t2_ifu_addr", 64'(mem_addr), 64'h200);
      cyc();
      mem_ready = 1'b0; mem_rdata = '0;

      // Store with ready in the last allowed wait cycle
      lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0010;
      lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h03;
      push_gnt(1'b1); push_rsp(1'b1, 32'h0, 1'b0);
      smp();
      check("t3_lsu_gnt", 64'(lsu_gnt), 64'd1);
      cyc();
      lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
      for (int i = 0; i < 3; i++) begin
         smp();
         check("t3_mem_valid", 64'(mem_valid), 64'd1);
         check("t3_mem_wen", 64'(mem_wen), 64'd1);
         check("t3_mem_wmask", 64'(mem_wmask), 64'h03);
         check("t3_mem_addr", 64'(mem_addr), 64'h8000_0010);
         check("t3_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
         check("t3_no_rvalid_yet", 64'(lsu_rvalid), 64'd0);
         cyc();
      end
      mem_ready = 1'b1;
      smp();
      check("t3_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
      check("t3_no_bus_err", 64'(bus_err), 64'd0);
      check("t3_mem_wen_last", 64'(mem_wen), 64'd1);
      cyc();

      // mem_ready while idle is ignored
      mem_rdata = 32'hCAFE;
      smp();
      check("idle_ready_ifu_rvalid", 64'(ifu_rvalid), 64'd0);
      check("idle_ready_lsu_rvalid", 64'(lsu_rvalid), 64'd0);
      check("idle_ready_mem_valid", 64'(mem_valid), 64'd0);
      cyc();
      mem_ready = 1'b0;

      // Timeout: no ready for 4 busy cycles
      mem_rdata = 32'hFFFF_FFFF;
      ifu_req = 1'b1; ifu_addr = 32'h1234;
      push_gnt(1'b0); push_rsp(1'b0, 32'h0, 1'b1);
      smp();
      check("t4_ifu_gnt", 64'(ifu_gnt), 64'd1);
      cyc();
      ifu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         check("t4_no_bus_err_early", 64'(bus_err), 64'd0);
         check("t4_no_rvalid_early", 64'(ifu_rvalid), 64'd0);
         cyc();
      end
      smp();
      check("t4_bus_err", 64'(bus_err), 64'd1);
      check("t4_ifu_rvalid", 64'(ifu_rvalid), 64'd1);
      check("t4_ifu_rdata", 64'(ifu_rdata), 64'd0);
      cyc();
      smp();
      check("t4_back_idle", 64'(mem_valid), 64'd0);
      check("t4_bus_err_pulse", 64'(bus_err), 64'd0);
      cyc();
      mem_rdata = '0;

      // Reset during an LSU transaction aborts it; next tie goes to LSU
      lsu_req = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h300;
      push_gnt(1'b1);
      smp();
      check("t5_lsu_gnt", 64'(lsu_gnt), 64'd1);
      cyc();
      lsu_req = 1'b0; rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h77;
      smp();
      check("t5_no_rvalid_in_rst", 64'(lsu_rvalid), 64'd0);
      check("t5_no_bus_err_in_rst", 64'(bus_err), 64'd0);
      cyc();
      rst = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      smp();
      check("t5_mem_valid_after_rst", 64'(mem_valid), 64'd0);
      cyc();
      ifu_req = 1'b1; ifu_addr = 32'h500; lsu_req = 1'b1; lsu_addr = 32'h400;
      push_gnt(1'b1); push_rsp(1'b1, 32'h99, 1'b0);
      smp();
      check("t5_tie_lsu_gnt", 64'(lsu_gnt), 64'd1);
      cyc();
      ifu_req = 1'b0; lsu_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h99;
      smp();
      check("t5_lsu_rvalid", 64'(lsu_rvalid), 64'd1);
      check("t5_lsu_addr", 64'(mem_addr), 64'h400);
      cyc();
      mem_ready = 1'b0; mem_rdata = '0;

      repeat (3) cyc();
      check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
      check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
